axi_wr_master: RTL and testbench
================================

Name: axi_wr_master

Overview:
- AXI4 write-master counterpart to the accelerator's AXI read-master port.
- Drains mul_tree_bf16 result beats (a valid/ready stream, M_AXI_DATA_WIDTH per beat) to external memory as INCR bursts on the AW/W/B channels.
- Driven by a single command: base address and beat count. Reports done and error back to ctrl.
- Exactly one burst is outstanding at a time.

Parameters:
- M_AXI_ID_WIDTH, 4, width of AWID/BID.
- M_AXI_DATA_WIDTH, 128 (`Tin*`DW), W data width; bytes per beat BPB = M_AXI_DATA_WIDTH/8.
- MAX_BURST, 16, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  32  byte base address; bits [log2(BPB)-1:0] ignored, treated as 0.
- cmd_beats  in  16  total beats to write.
- s_data  in  M_AXI_DATA_WIDTH  result beat.
- s_valid  in  1  result beat valid.
- s_ready  out  1  result beat accepted when s_valid && s_ready.
- busy  out  1  high from command accept until the done pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky; set on any BRESP != 2'b00; cleared on next command accept.
- M_AXI_AWID  out  M_AXI_ID_WIDTH  constant 0.
- M_AXI_AWADDR  out  32  burst start address.
- M_AXI_AWLEN  out  8  beats-1.
- M_AXI_AWSIZE  out  3  log2(BPB) (3'd4 at default).
- M_AXI_AWBURST  out  2  2'b01.
- M_AXI_AWLOCK  out  1  0.
- M_AXI_AWCACHE  out  4  4'b0010.
- M_AXI_AWPROT  out  3  0.
- M_AXI_AWQOS  out  4  0.
- M_AXI_AWVALID  out  1  address valid.
- M_AXI_AWREADY  in  1  address ready.
- M_AXI_WDATA  out  M_AXI_DATA_WIDTH  = s_data.
- M_AXI_WSTRB  out  BPB  all ones.
- M_AXI_WLAST  out  1  last beat of burst.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BID  in  M_AXI_ID_WIDTH  ignored.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  response valid.
- M_AXI_BREADY  out  1  high only in B_WAIT.

Behaviour:
- States: IDLE, AW, W, B_WAIT, DONE.
- Reset:
  - State goes to IDLE.
  - AWVALID, WVALID, BREADY, busy, done, err, s_ready are all 0; cmd_ready is 1.
  - AWADDR and AWLEN are 0.
  - Reset mid-burst abandons the transaction immediately; no completion of the AXI burst is attempted.
- IDLE, command accept (cmd_valid && cmd_ready) in cycle T:
  - Latch the aligned address and remaining = cmd_beats; clear err; busy=1 from T+1.
  - If cmd_beats==0: go to DONE (done high at T+1), no AXI traffic.
  - Otherwise: go to AW; AWVALID=1 at T+1.
- Burst length:
  - len = min(remaining, MAX_BURST, beats_to_4KB), where beats_to_4KB = (4096 - addr[11:0]) / BPB.
  - Computed on entry to AW, registered, and held stable while AWVALID=1.
  - AWLEN = len-1.
  - No burst may cross a 4KB boundary.
- AW:
  - AWVALID stays high with AWADDR/AWLEN stable until AWREADY.
  - On the handshake: AWVALID=0 the next cycle; go to W; beat counter = 0.
- W (passthrough, no internal buffering):
  - WVALID = s_valid; s_ready = WREADY; WDATA = s_data.
  - WVALID must never depend combinationally on WREADY.
  - WLAST = (beat counter == len-1).
  - On each W handshake the beat counter increments.
  - On the WLAST handshake: remaining -= len; addr += len*BPB; go to B_WAIT.
  - Outside the W state, s_ready=0 and WVALID=0.
- B_WAIT:
  - BREADY=1.
  - On BVALID: if BRESP != 0, set err.
  - Then if remaining > 0, go to AW (next AWVALID the cycle after the B handshake); else go to DONE.
  - An error does not abort: the remaining bursts are still issued so the upstream stream drains fully.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy=0 and cmd_ready=1 in the IDLE cycle that follows.
- cmd_valid while busy is ignored (cmd_ready=0).
- Simultaneous AWREADY arriving in the same cycle AWVALID first rises is a valid handshake.
- BVALID arriving in the same cycle BREADY rises is accepted.
- Max cmd_beats 65535; address wraps modulo 2^32.

Test Plan:
- rst held 3 cycles mid-AW -> next cycle all valids 0, cmd_ready=1, busy=0; a new command then runs cleanly.
- cmd_addr=0x1000, cmd_beats=40, slaves always ready -> three bursts: AW 0x1000/AWLEN 15, 0x1100/15, 0x1200/7; WLAST on beats 16, 32, 40; done one cycle after the third B; err=0.
- cmd_addr=0x1FC0, cmd_beats=10 -> bursts 0x1FC0/AWLEN 3 (4 beats to 4KB), then 0x2000/AWLEN 5; no burst crosses 0x2000.
- cmd_beats=0 -> done pulses at T+1, AWVALID never asserts, busy high for exactly 1 cycle.
- Random WREADY/s_valid/AWREADY/BVALID stalls, cmd_beats=20 -> all 20 s_data words appear on WDATA in order; AWADDR/AWLEN stable while AWVALID && !AWREADY; no W beat before its AW handshake.
- BRESP=2'b10 on first of two bursts (cmd_beats=32) -> second burst still issued; err=1 at done; next command accept clears err.

Source files
------------

// File: rtl/axi_wr_master.sv
// AXI4 write master: drains a valid/ready result stream to memory as INCR
// bursts, one burst outstanding at a time, never crossing a 4KB page.
module axi_wr_master #(
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int M_AXI_DATA_WIDTH = 128,
  parameter int MAX_BURST        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [31:0]                   cmd_addr,
  input  logic [15:0]                   cmd_beats,
  input  logic [M_AXI_DATA_WIDTH-1:0]   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [31:0]                   M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);
  localparam int BPB = M_AXI_DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam logic [31:0] ALIGN_MASK = ~32'(BPB - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [7:0]  len_m1;
  logic [7:0]  beat_cnt;
  logic        err_q;

  logic [31:0] cmd_addr_al;
  logic [11:0] src_lo;
  logic [15:0] src_rem;
  logic [12:0] to_4k;
  logic [16:0] lmin;
  logic        w_hs, w_last, aw_hs, b_hs, cmd_acc, enter_aw;
  logic        unused_bid;

  assign unused_bid  = &{1'b0, M_AXI_BID};
  assign cmd_addr_al = cmd_addr & ALIGN_MASK;

  // Burst length source: the command itself when leaving IDLE, otherwise the
  // running address/remaining (already advanced by the previous burst).
  assign src_lo  = (state == S_IDLE) ? cmd_addr_al[11:0] : addr[11:0];
  assign src_rem = (state == S_IDLE) ? cmd_beats : remaining;
  assign to_4k   = (13'd4096 - {1'b0, src_lo}) >> SZ;

  // len = min(remaining, MAX_BURST, beats left in the 4KB page)
  always_comb begin
    lmin = {1'b0, src_rem};
    if (lmin > 17'(MAX_BURST)) lmin = 17'(MAX_BURST);
    if (lmin > {4'b0, to_4k})  lmin = {4'b0, to_4k};
  end

  assign cmd_acc  = cmd_valid && (state == S_IDLE);
  assign aw_hs    = (state == S_AW) && M_AXI_AWREADY;
  assign w_hs     = (state == S_W) && s_valid && M_AXI_WREADY;
  assign w_last   = (beat_cnt == len_m1);
  assign b_hs     = (state == S_B_WAIT) && M_AXI_BVALID;
  assign enter_aw = (state_nxt == S_AW) && (state != S_AW);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; valids decode from the registered state
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    s_ready       = 1'b0;
    M_AXI_BREADY  = 1'b0;
    done          = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_beats == 16'd0) ? S_DONE : S_AW;
      end
      S_AW: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_nxt = S_W;
      end
      S_W: begin
        M_AXI_WVALID = s_valid;
        s_ready      = M_AXI_WREADY;
        if (w_hs && w_last) state_nxt = S_B_WAIT;
      end
      S_B_WAIT: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = (remaining != 16'd0) ? S_AW : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address/remaining bookkeeping, burst length, beat counter, error
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= 32'd0;
      remaining <= 16'd0;
      len_m1    <= 8'd0;
      beat_cnt  <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (cmd_acc) begin
        addr      <= cmd_addr_al;
        remaining <= cmd_beats;
        err_q     <= 1'b0;
      end
      if (enter_aw) len_m1 <= 8'(lmin - 17'd1);
      if (aw_hs) beat_cnt <= 8'd0;
      if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (w_last) begin
          remaining <= remaining - (16'(len_m1) + 16'd1);
          addr      <= addr + ((32'(len_m1) + 32'd1) << SZ);
        end
      end
      if (b_hs && (M_AXI_BRESP != 2'b00)) err_q <= 1'b1;
    end
  end

  assign err           = err_q;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = len_m1;
  assign M_AXI_AWSIZE  = 3'(SZ);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0010;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_WDATA   = s_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state == S_W) && w_last;

endmodule

// File: tb/tb_axi_wr_master.sv
// Bench for axi_wr_master: table of commands plus random ones, each checked
// cycle by cycle against a burst-list/data-queue reference model.
module tb_axi_wr_master;
  localparam int IDW = 4;
  localparam int DW  = 128;
  localparam int MB  = 16;
  localparam int BPB = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready;
  logic [31:0]     cmd_addr;
  logic [15:0]     cmd_beats;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic            busy, done, err;
  logic [IDW-1:0]  M_AXI_AWID;
  logic [31:0]     M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic            M_AXI_AWLOCK;
  logic [3:0]      M_AXI_AWCACHE;
  logic [2:0]      M_AXI_AWPROT;
  logic [3:0]      M_AXI_AWQOS;
  logic            M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [BPB-1:0]  M_AXI_WSTRB;
  logic            M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [IDW-1:0]  M_AXI_BID;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID, M_AXI_BREADY;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_wr_master #(.M_AXI_ID_WIDTH(IDW), .M_AXI_DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .err(err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          err_burst;   // index of burst answered with SLVERR, -1 none
    int          pct;         // ready/valid probability for slaves and source
    int          exp_nb;      // expected AW handshakes
    int          exp_awlen0;  // expected AWLEN of first burst, -1 none
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_awvalid"}, 128'(M_AXI_AWVALID), 128'(0));
    chk({tag, "_wvalid"},  128'(M_AXI_WVALID),  128'(0));
    chk({tag, "_bready"},  128'(M_AXI_BREADY),  128'(0));
    chk({tag, "_sready"},  128'(s_ready),       128'(0));
    chk({tag, "_cmdrdy"},  128'(cmd_ready),     128'(1));
    chk({tag, "_busy"},    128'(busy),          128'(0));
    chk({tag, "_done"},    128'(done),          128'(0));
    chk({tag, "_err"},     128'(err),           128'(0));
    chk({tag, "_awaddr"},  128'(M_AXI_AWADDR),  128'(0));
    chk({tag, "_awlen"},   128'(M_AXI_AWLEN),   128'(0));
  endtask

  // One command end to end. The model is the list of (addr,len) bursts the
  // command must split into, plus the queue of data words to be written.
  task automatic run_cmd(input logic [31:0] a, input int beats, input int err_burst,
                         input int pct, input int exp_nb, input int exp_awlen0, input bit exp_err);
    logic [31:0]  ba[$];
    int           bl[$];
    logic [127:0] dq[$];
    logic [31:0]  ma, prev_awaddr;
    logic [7:0]   prev_awlen;
    int rem, l, b2k, nb;
    int aw_cnt = 0, w_burst = 0, wbeat = 0, src = 0, b_cnt = 0, b_owed = 0, cyc = 0;
    int first_awlen = -1;
    bit finished = 0, in_w, exp_awv, prev_aw_pend = 0;

    ma  = a & ~32'(BPB - 1);
    rem = beats;
    while (rem > 0) begin
      b2k = (4096 - int'(ma[11:0])) / BPB;
      l = rem;
      if (l > MB)  l = MB;
      if (l > b2k) l = b2k;
      ba.push_back(ma);
      bl.push_back(l);
      ma  = ma + 32'(l * BPB);
      rem = rem - l;
    end
    nb = ba.size();
    for (int i = 0; i < beats; i++) dq.push_back({$urandom, $urandom, $urandom, $urandom});

    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cmd_valid = (cyc == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      cmd_addr  = (cyc == 0) ? a : $urandom;
      cmd_beats = (cyc == 0) ? 16'(beats) : 16'($urandom);
      M_AXI_AWREADY = ($urandom_range(0, 99) < pct);
      M_AXI_WREADY  = ($urandom_range(0, 99) < pct);
      s_valid       = ($urandom_range(0, 99) < pct);
      s_data        = (src < beats) ? dq[src] : {$urandom, $urandom, $urandom, $urandom};
      if (b_owed == 0)        M_AXI_BVALID = 1'b0;
      else if (!M_AXI_BVALID) M_AXI_BVALID = ($urandom_range(0, 99) < pct);
      M_AXI_BRESP = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      M_AXI_BID   = 4'($urandom);
      #1;
      in_w    = (w_burst < nb) && (aw_cnt > w_burst);
      exp_awv = (cyc >= 1) && (aw_cnt < nb) && (aw_cnt == b_cnt);
      chk("cmd_ready", 128'(cmd_ready), 128'(cyc == 0));
      chk("busy",      128'(busy),      128'(cyc != 0));
      chk("done",      128'(done),      128'((cyc >= 1) && (b_cnt == nb)));
      chk("awvalid",   128'(M_AXI_AWVALID), 128'(exp_awv));
      if (M_AXI_AWVALID && aw_cnt < nb) begin
        chk("awaddr", 128'(M_AXI_AWADDR), 128'(ba[aw_cnt]));
        chk("awlen",  128'(M_AXI_AWLEN),  128'(bl[aw_cnt] - 1));
      end
      if (prev_aw_pend) begin
        chk("aw_held",   128'(M_AXI_AWVALID), 128'(1));
        chk("aw_stable", 128'({M_AXI_AWADDR, M_AXI_AWLEN}), 128'({prev_awaddr, prev_awlen}));
      end
      chk("wvalid", 128'(M_AXI_WVALID), 128'(s_valid && in_w));
      chk("s_ready", 128'(s_ready), 128'(M_AXI_WREADY && in_w));
      chk("bready", 128'(M_AXI_BREADY), 128'(b_owed > 0));
      if (M_AXI_WVALID && in_w) begin
        chk("wdata", M_AXI_WDATA, dq[src]);
        chk("wlast", 128'(M_AXI_WLAST), 128'(wbeat == bl[w_burst] - 1));
      end
      if (cyc == 1) chk("err_cleared", 128'(err), 128'(0));

      prev_aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
      prev_awaddr  = M_AXI_AWADDR;
      prev_awlen   = M_AXI_AWLEN;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (aw_cnt == 0) first_awlen = int'(M_AXI_AWLEN);
        aw_cnt++;
      end
      if (M_AXI_WVALID && M_AXI_WREADY && in_w) begin
        src++;
        wbeat++;
        if (wbeat == bl[w_burst]) begin
          wbeat = 0;
          w_burst++;
          b_owed++;
        end
      end
      if (M_AXI_BVALID && M_AXI_BREADY && b_owed > 0) begin
        b_cnt++;
        b_owed--;
      end
      if (done) begin
        finished = 1;
        chk("err_at_done", 128'(err), 128'(exp_err));
        chk("beats_written", 128'(src), 128'(beats));
        chk("aw_count", 128'(aw_cnt), 128'((exp_nb >= 0) ? exp_nb : nb));
        if (exp_awlen0 >= 0) chk("first_awlen", 128'(first_awlen), 128'(exp_awlen0));
      end
      cyc++;
    end
    if (!finished) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout: no done after %0d cycles (addr %0h beats %0d)", cyc, a, beats);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    s_data = '0; s_valid = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    M_AXI_BID = '0; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");
    chk("awsize",  128'(M_AXI_AWSIZE),  128'(4));
    chk("awburst", 128'(M_AXI_AWBURST), 128'(1));
    chk("awcache", 128'(M_AXI_AWCACHE), 128'(2));
    chk("wstrb",   128'(M_AXI_WSTRB),   128'(16'hFFFF));

    // Reset while AWVALID is stalled: the burst is abandoned outright.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0800; cmd_beats = 16'd8; M_AXI_AWREADY = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("mid_aw_valid", 128'(M_AXI_AWVALID), 128'(1));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("mid_rst");

    //            addr          beats err pct  nb awlen0 err
    vecs.push_back('{32'h0000_1000, 40, -1, 100, 3, 15, 1'b0});
    vecs.push_back('{32'h0000_1FC0, 10, -1, 100, 2,  3, 1'b0});
    vecs.push_back('{32'h0000_2000,  0, -1, 100, 0, -1, 1'b0});
    vecs.push_back('{32'h2000_0004, 20, -1,  50, 2, 15, 1'b0});
    vecs.push_back('{32'h0000_3000, 32,  0, 100, 2, 15, 1'b1});
    vecs.push_back('{32'h0000_4000,  5, -1, 100, 1,  4, 1'b0});
    vecs.push_back('{32'hFFFF_FFE0,  6, -1,  60, 2,  1, 1'b0});
    vecs.push_back('{32'h0000_5008, 20, -1,  30, 2, 15, 1'b0});
    vecs.push_back('{32'h0000_6F00, 24,  1,  40, 2, 15, 1'b1});
    foreach (vecs[i])
      run_cmd(vecs[i].addr, vecs[i].beats, vecs[i].err_burst, vecs[i].pct,
              vecs[i].exp_nb, vecs[i].exp_awlen0, vecs[i].exp_err);

    for (int k = 0; k < 5; k++)
      run_cmd($urandom, $urandom_range(1, 50), -1, $urandom_range(30, 100), -1, -1, 1'b0);

    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("final_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("final_busy",      128'(busy),      128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
